// File: rtl/snoop_responder_pkg.sv
// rtl/snoop_responder_pkg.sv - shared types for the per-core snoop agent
package snoop_responder_pkg;

  typedef enum logic [1:0] {
    INVALID  = 2'b00,
    SHARED   = 2'b01,
    MODIFIED = 2'b10
  } line_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10,
    FWD  = 2'b11
  } snoop_fsm_t;

  typedef enum logic {
    SEARCH = 1'b0,
    INV    = 1'b1
  } snoop_op_t;

  // A line counts as held only in SHARED or MODIFIED; the unused 2'b11 encoding reads as INVALID.
  function automatic logic line_valid(input logic [1:0] st);
    return (st == SHARED) || (st == MODIFIED);
  endfunction

endpackage

// File: rtl/snoop_responder_if.sv
// rtl/snoop_responder_if.sv - bus-side and cache-side signals of the snoop agent
interface snoop_responder_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) ();

  logic              search;
  logic              snp_inv;
  logic [ADDR_W-1:0] snp_addr;
  logic              search_found;
  logic              search_done;
  logic              fwd_valid;
  logic [DATA_W-1:0] fwd_data;
  logic              busy;

  logic              cache_req;
  logic              cache_gnt;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_hit;
  logic [1:0]        cache_state;
  logic [DATA_W-1:0] cache_data;
  logic              cache_upd;
  logic [1:0]        cache_new_state;

  // Environment view: bus arbiter plus the cache snoop port.
  modport master (
    output search, snp_inv, snp_addr, cache_gnt, cache_hit, cache_state, cache_data,
    input  search_found, search_done, fwd_valid, fwd_data, busy,
    input  cache_req, cache_addr, cache_upd, cache_new_state
  );

  // Snoop agent view.
  modport slave (
    input  search, snp_inv, snp_addr, cache_gnt, cache_hit, cache_state, cache_data,
    output search_found, search_done, fwd_valid, fwd_data, busy,
    output cache_req, cache_addr, cache_upd, cache_new_state
  );

endinterface

// File: rtl/snoop_responder.sv
// rtl/snoop_responder.sv - snoop agent: cache lookup, data forward, downgrade/invalidate
module snoop_responder
  import snoop_responder_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 16,
  parameter int FWD_HOLD = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  snoop_responder_if.slave bus
);

  localparam int CNT_W = $clog2(FWD_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(FWD_HOLD - 1);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_REQ  = 2'(REQ);
  localparam logic [1:0] ST_RESP = 2'(RESP);
  localparam logic [1:0] ST_FWD  = 2'(FWD);

  logic [1:0]        state_q;
  snoop_op_t         op_q;
  logic [ADDR_W-1:0] addr_q;
  logic              hit_q;
  logic [1:0]        lstate_q;
  logic [DATA_W-1:0] data_q;
  logic              found_q;
  logic [CNT_W-1:0]  cnt_q;

  logic line_ok;
  logic do_upd;
  logic do_fwd;
  logic in_resp;

  // Decisions are taken from the line snapshot captured on the grant cycle.
  assign line_ok = hit_q && line_valid(lstate_q);
  assign do_upd  = line_ok && ((op_q == INV) || (lstate_q == MODIFIED));
  assign do_fwd  = line_ok && ((op_q == SEARCH) || (lstate_q == MODIFIED));
  assign in_resp = (state_q == ST_RESP);

  assign bus.busy            = (state_q != ST_IDLE);
  assign bus.cache_req       = (state_q == ST_REQ);
  assign bus.search_done     = in_resp;
  assign bus.search_found    = found_q;
  assign bus.cache_upd       = in_resp && do_upd;
  assign bus.cache_new_state = (in_resp && do_upd) ? ((op_q == INV) ? INVALID : SHARED) : INVALID;
  assign bus.cache_addr      = (bus.cache_req || bus.cache_upd) ? addr_q : '0;
  assign bus.fwd_valid       = (in_resp && do_fwd) || (state_q == ST_FWD);
  assign bus.fwd_data        = bus.fwd_valid ? data_q : '0;

  // Snoop FSM: accept in IDLE, wait for grant, answer, then optionally hold the forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      op_q     <= SEARCH;
      addr_q   <= '0;
      hit_q    <= 1'b0;
      lstate_q <= 2'b00;
      data_q   <= '0;
      found_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.search || bus.snp_inv) begin
            addr_q  <= bus.snp_addr;
            op_q    <= bus.snp_inv ? INV : SEARCH;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.cache_gnt) begin
            hit_q    <= bus.cache_hit;
            lstate_q <= bus.cache_state;
            data_q   <= bus.cache_data;
            // Registered here so search_found is already valid alongside search_done.
            found_q  <= bus.cache_hit && line_valid(bus.cache_state);
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (do_fwd && (FWD_HOLD > 1)) begin
            cnt_q   <= CNT_W'(1);
            state_q <= ST_FWD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_FWD: begin
          if (cnt_q >= HOLD_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_responder.sv
// tb/tb_snoop_responder.sv - scoreboard bench for the snoop agent
module tb_snoop_responder;
  import snoop_responder_pkg::*;

  localparam int FWD_HOLD = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic        exp_found_q[$];
  int          exp_done_cyc_q[$];
  logic [6:0]  exp_upd_q[$];
  logic [15:0] exp_fwd_data_q[$];
  int          exp_fwd_cyc_q[$];

  snoop_responder_if #(.ADDR_W(5), .DATA_W(16)) sif ();

  snoop_responder #(.ADDR_W(5), .DATA_W(16), .FWD_HOLD(FWD_HOLD)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (sif.slave)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sif.search_done) begin
        chk("done_expected", 32'(exp_done_cyc_q.size() != 0), 32'd1);
        if (exp_done_cyc_q.size() != 0) begin
          chk("done_cycle", 32'(cyc), 32'(exp_done_cyc_q.pop_front()));
          chk("search_found", 32'(sif.search_found), 32'(exp_found_q.pop_front()));
        end
      end
      if (sif.cache_upd) begin
        chk("upd_expected", 32'(exp_upd_q.size() != 0), 32'd1);
        if (exp_upd_q.size() != 0)
          chk("upd_addr_state", 32'({sif.cache_addr, sif.cache_new_state}), 32'(exp_upd_q.pop_front()));
      end
      if (sif.fwd_valid) begin
        chk("fwd_expected", 32'(exp_fwd_cyc_q.size() != 0), 32'd1);
        if (exp_fwd_cyc_q.size() != 0) begin
          chk("fwd_cycle", 32'(cyc), 32'(exp_fwd_cyc_q.pop_front()));
          chk("fwd_data", 32'(sif.fwd_data), 32'(exp_fwd_data_q.pop_front()));
        end
      end
    end
  end

  // mode: 0 normal, 1 toggle search while waiting for grant, 2 reset during FWD.
  task automatic snoop(input logic s, input logic inv, input logic [4:0] a, input int dly,
                       input logic hit, input logic [1:0] st, input logic [15:0] d, input int mode,
                       input logic e_found, input logic e_upd, input logic [1:0] e_new, input logic e_fwd);
    int t0;
    int n;
    sif.search    = s;
    sif.snp_inv   = inv;
    sif.snp_addr  = a;
    sif.cache_gnt = 1'b0;
    t0 = cyc;
    exp_found_q.push_back(e_found);
    exp_done_cyc_q.push_back(t0 + 2 + dly);
    if (e_upd) exp_upd_q.push_back({a, e_new});
    if (e_fwd) begin
      for (int k = 0; k < ((mode == 2) ? 1 : FWD_HOLD); k++) begin
        exp_fwd_data_q.push_back(d);
        exp_fwd_cyc_q.push_back(t0 + 2 + dly + k);
      end
    end
    @(negedge clk);
    chk("busy_after_accept", 32'(sif.busy), 32'd1);
    sif.snp_addr = ~a;
    if (mode != 1) begin
      sif.search  = 1'b0;
      sif.snp_inv = 1'b0;
    end
    sif.cache_hit   = hit;
    sif.cache_state = st;
    sif.cache_data  = d;
    for (int w = 0; w < dly; w++) begin
      chk("req_held", 32'(sif.cache_req), 32'd1);
      chk("addr_stable", 32'(sif.cache_addr), 32'(a));
      if (mode == 1) sif.search = ~sif.search;
      @(negedge clk);
    end
    sif.search    = 1'b0;
    sif.snp_inv   = 1'b0;
    sif.cache_gnt = 1'b1;
    chk("req_at_gnt", 32'(sif.cache_req), 32'd1);
    chk("addr_at_gnt", 32'(sif.cache_addr), 32'(a));
    @(negedge clk);
    // Grant with junk outside REQ must be ignored.
    sif.cache_hit   = ~hit;
    sif.cache_state = 2'b10;
    sif.cache_data  = 16'hDEAD;
    if (mode == 2) begin
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_fwd_valid", 32'(sif.fwd_valid), 32'd0);
      chk("rst_busy", 32'(sif.busy), 32'd0);
      chk("rst_fwd_data", 32'(sif.fwd_data), 32'd0);
      chk("rst_cache_upd", 32'(sif.cache_upd), 32'd0);
      chk("rst_state_idle", 32'(dut.state_q), 32'd0);
      chk("rst_queues_empty", 32'(exp_fwd_cyc_q.size() + exp_upd_q.size() + exp_done_cyc_q.size()), 32'd0);
      sif.cache_gnt = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      for (n = 0; n < 20 && sif.busy; n++) @(negedge clk);
      sif.cache_gnt = 1'b0;
      chk("idle_reached", 32'(sif.busy), 32'd0);
      chk("idle_cycle", 32'(cyc), 32'(t0 + 3 + dly + (e_fwd ? FWD_HOLD - 1 : 0)));
      chk("found_held", 32'(sif.search_found), 32'(e_found));
    end
  endtask

  // Watchdog against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Directed stimulus sequence.
  initial begin
    sif.search      = 1'b1;
    sif.snp_inv     = 1'b0;
    sif.snp_addr    = 5'h11;
    sif.cache_gnt   = 1'b0;
    sif.cache_hit   = 1'b0;
    sif.cache_state = 2'b00;
    sif.cache_data  = 16'h0;
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("reset_outputs", 32'({sif.search_found, sif.search_done, sif.fwd_valid, sif.fwd_data,
                                sif.busy, sif.cache_req, sif.cache_addr, sif.cache_upd,
                                sif.cache_new_state}), 32'd0);
    end
    rst_n = 1'b1;
    //     s     inv   addr   dly hit   state     data      mode found upd  new       fwd
    snoop(1'b1, 1'b0, 5'h11, 0, 1'b1, 2'b01, 16'h1234, 0, 1'b1, 1'b0, 2'b00, 1'b1);
    snoop(1'b1, 1'b0, 5'h0A, 0, 1'b1, 2'b10, 16'hBEEF, 0, 1'b1, 1'b1, 2'b01, 1'b1);
    snoop(1'b1, 1'b0, 5'h03, 0, 1'b1, 2'b01, 16'h5A5A, 0, 1'b1, 1'b0, 2'b00, 1'b1);
    snoop(1'b1, 1'b0, 5'h03, 0, 1'b0, 2'b01, 16'h5A5A, 0, 1'b0, 1'b0, 2'b00, 1'b0);
    snoop(1'b1, 1'b1, 5'h0A, 0, 1'b1, 2'b10, 16'hCAFE, 0, 1'b1, 1'b1, 2'b00, 1'b1);
    snoop(1'b0, 1'b1, 5'h07, 0, 1'b1, 2'b01, 16'h1111, 0, 1'b1, 1'b1, 2'b00, 1'b0);
    snoop(1'b1, 1'b0, 5'h1F, 4, 1'b1, 2'b01, 16'h0F0F, 1, 1'b1, 1'b0, 2'b00, 1'b1);
    snoop(1'b1, 1'b0, 5'h12, 0, 1'b1, 2'b11, 16'hABCD, 0, 1'b0, 1'b0, 2'b00, 1'b0);
    snoop(1'b0, 1'b1, 5'h04, 1, 1'b0, 2'b10, 16'h2222, 0, 1'b0, 1'b0, 2'b00, 1'b0);
    snoop(1'b1, 1'b0, 5'h0A, 0, 1'b1, 2'b10, 16'h9999, 2, 1'b1, 1'b1, 2'b01, 1'b1);
    snoop(1'b1, 1'b0, 5'h0A, 0, 1'b1, 2'b10, 16'h7777, 0, 1'b1, 1'b1, 2'b01, 1'b1);
    repeat (5) @(negedge clk);
    chk("final_done_queue", 32'(exp_done_cyc_q.size()), 32'd0);
    chk("final_upd_queue", 32'(exp_upd_q.size()), 32'd0);
    chk("final_fwd_queue", 32'(exp_fwd_cyc_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
